// File: rtl/endp_inject_arbiter.sv
// Injection arbiter: shares one router local-port channel among NREQ endpoint
// requesters with packet-level round-robin, wormhole lock and per-VC credits.
module endp_inject_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned V      = 2,
  parameter int unsigned B      = 4,
  localparam int unsigned VW    = (V > 1) ? $clog2(V) : 1,
  localparam int unsigned CW    = $clog2(B + 1),
  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*FLIT_W-1:0] req_flit,
  input  logic [NREQ-1:0]        req_hdr,
  input  logic [NREQ-1:0]        req_tail,
  input  logic [NREQ*VW-1:0]     req_vc,
  output logic [NREQ-1:0]        req_ready,
  input  logic [V-1:0]           credit_in,
  output logic [FLIT_W-1:0]      flit_out,
  output logic                   flit_out_wr,
  output logic                   flit_out_hdr,
  output logic                   flit_out_tail,
  output logic [V-1:0]           flit_out_vc,
  output logic                   busy,
  output logic                   credit_err,
  output logic                   proto_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   lock_id_q;
  logic [PW-1:0]   lock_id_d;
  logic [VW-1:0]   lock_vc_q;
  logic [VW-1:0]   lock_vc_d;
  logic [PW-1:0]   grant_id;
  logic [PW-1:0]   cand;
  logic [VW-1:0]   send_vc;
  logic [V-1:0]    send_oh;
  logic [V-1:0]    send_hit;
  logic            accept;
  logic [VW-1:0]   vc_a [NREQ];
  logic [CW-1:0]   credit_q [V];
  logic [V-1:0]    has_credit;
  logic [NREQ-1:0] eligible;

  // Out-of-range VC indices (non power-of-two V) never have credit.
  function automatic logic vc_ok(input logic [VW-1:0] vc, input logic [V-1:0] hc);
    logic ok;
    ok = 1'b0;
    for (int v = 0; v < V; v++) begin
      if (vc == VW'(v)) ok = hc[v];
    end
    return ok;
  endfunction

  function automatic logic [PW-1:0] next_id(input logic [PW-1:0] id);
    return (32'(id) == NREQ - 1) ? '0 : id + PW'(1);
  endfunction

  always_comb begin
    for (int v = 0; v < V; v++) begin
      has_credit[v] = (credit_q[v] != '0);
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      vc_a[i]     = req_vc[i*VW +: VW];
      eligible[i] = req_valid[i] & req_hdr[i] & vc_ok(vc_a[i], has_credit);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lock_id_q <= '0;
      lock_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  // FSM outputs: grant selection and combinational ready
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    grant_id  = '0;
    cand      = '0;
    send_vc   = '0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = PW'((32'(ptr_q) + 32'(k)) % NREQ);
        if (!accept && eligible[cand]) begin
          accept   = 1'b1;
          grant_id = cand;
        end
      end
      if (accept) send_vc = vc_a[grant_id];
    end else if (req_valid[lock_id_q] && vc_ok(lock_vc_q, has_credit)) begin
      accept   = 1'b1;
      grant_id = lock_id_q;
      send_vc  = lock_vc_q;
    end
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // FSM next state: lock on a multi-flit header, release on its tail
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    lock_vc_d = lock_vc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_tail[grant_id]) begin
            ptr_d = next_id(grant_id);
          end else begin
            state_d   = BUSY;
            lock_id_d = grant_id;
            lock_vc_d = send_vc;
          end
        end
      end
      BUSY: begin
        if (accept && req_tail[lock_id_q]) begin
          state_d = IDLE;
          ptr_d   = next_id(lock_id_q);
        end
      end
    endcase
  end

  always_comb begin
    for (int v = 0; v < V; v++) begin
      send_oh[v]  = (send_vc == VW'(v));
      send_hit[v] = accept & send_oh[v];
    end
  end

  // Per-VC credit counters; a return at full count saturates and flags an error
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) begin
        credit_q[v] <= CW'(B);
      end
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) begin
        if (send_hit[v] && !credit_in[v]) begin
          credit_q[v] <= credit_q[v] - CW'(1);
        end else if (!send_hit[v] && credit_in[v]) begin
          if (credit_q[v] == CW'(B)) credit_err <= 1'b1;
          else                       credit_q[v] <= credit_q[v] + CW'(1);
        end
      end
    end
  end

  // Registered flit write side; payload holds when nothing is accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      flit_out      <= '0;
      flit_out_wr   <= 1'b0;
      flit_out_hdr  <= 1'b0;
      flit_out_tail <= 1'b0;
      flit_out_vc   <= '0;
      proto_err     <= 1'b0;
    end else begin
      flit_out_wr <= accept;
      if (accept) begin
        flit_out      <= req_flit[32'(grant_id)*FLIT_W +: FLIT_W];
        flit_out_hdr  <= (state_q == IDLE);
        flit_out_tail <= req_tail[grant_id];
        flit_out_vc   <= send_oh;
      end
      if (state_q == IDLE && |(req_valid & ~req_hdr)) proto_err <= 1'b1;
    end
  end

  assign busy = (state_q == BUSY);

endmodule

// File: tb/tb_endp_inject_arbiter.sv
// Bench for endp_inject_arbiter: directed vector table, a hold sequence, and
// random traffic checked against a packet-level reference model.
module tb_endp_inject_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned FLIT_W = 32;
  localparam int unsigned V      = 2;
  localparam int unsigned B      = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_flit;
  logic [3:0]   req_hdr;
  logic [3:0]   req_tail;
  logic [3:0]   req_vc;
  logic [3:0]   req_ready;
  logic [1:0]   credit_in;
  logic [31:0]  flit_out;
  logic         flit_out_wr;
  logic         flit_out_hdr;
  logic         flit_out_tail;
  logic [1:0]   flit_out_vc;
  logic         busy;
  logic         credit_err;
  logic         proto_err;

  endp_inject_arbiter #(.NREQ(NREQ), .FLIT_W(FLIT_W), .V(V), .B(B)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_flit(req_flit), .req_hdr(req_hdr),
    .req_tail(req_tail), .req_vc(req_vc), .req_ready(req_ready),
    .credit_in(credit_in), .flit_out(flit_out), .flit_out_wr(flit_out_wr),
    .flit_out_hdr(flit_out_hdr), .flit_out_tail(flit_out_tail),
    .flit_out_vc(flit_out_vc), .busy(busy), .credit_err(credit_err),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int          m_cred [2];
  int          m_ptr;
  bit          m_lock;
  int          m_lid;
  int          m_lvc;
  bit          m_perr;
  bit          m_cerr;
  bit          m_wr;
  bit          m_hdr;
  bit          m_tail;
  logic [31:0] m_flit;
  logic [1:0]  m_vc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] model_ready(input logic [3:0] v, input logic [3:0] h,
                                             input logic [3:0] vc);
    if (m_lock) return (v[m_lid] && m_cred[m_lvc] > 0) ? 4'(1 << m_lid) : 4'b0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (v[i] && h[i] && m_cred[vc[i]] > 0) return 4'(1 << i);
    end
    return 4'b0;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] v, input logic [3:0] h,
                            input logic [3:0] t, input logic [3:0] vc,
                            input logic [1:0] ci, input logic [3:0] rdy);
    int id;
    int svc;
    bit acc;
    bit s;
    if (!r) begin
      m_cred[0] = B; m_cred[1] = B; m_ptr = 0; m_lock = 0; m_lid = 0; m_lvc = 0;
      m_perr = 0; m_cerr = 0; m_wr = 0; m_hdr = 0; m_tail = 0; m_flit = '0; m_vc = '0;
      return;
    end
    acc = (rdy != 4'b0);
    id  = 0;
    for (int i = 0; i < 4; i++) if (rdy[i]) id = i;
    svc = m_lock ? m_lvc : int'(vc[id]);
    if (!m_lock && ((v & ~h) != 4'b0)) m_perr = 1;
    m_wr = acc;
    if (acc) begin
      m_flit = req_flit[id*32 +: 32];
      m_hdr  = !m_lock;
      m_tail = t[id];
      m_vc   = 2'(1 << svc);
    end
    for (int k = 0; k < 2; k++) begin
      s = acc && (svc == k);
      if (s && !ci[k]) m_cred[k]--;
      else if (!s && ci[k]) begin
        if (m_cred[k] == B) m_cerr = 1;
        else m_cred[k]++;
      end
    end
    if (acc) begin
      if (!m_lock) begin
        if (t[id]) m_ptr = (id + 1) % 4;
        else begin m_lock = 1; m_lid = id; m_lvc = svc; end
      end else if (t[id]) begin
        m_lock = 0;
        m_ptr  = (m_lid + 1) % 4;
      end
    end
  endtask

  // One clock: drive at negedge, check ready, then registered outputs after posedge
  task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] h,
                       input logic [3:0] t, input logic [3:0] vc, input logic [1:0] ci,
                       output logic [3:0] rdy, output logic [3:0] dut_rdy);
    @(negedge clk);
    cyc++;
    reset = r; req_valid = v; req_hdr = h; req_tail = t; req_vc = vc; credit_in = ci;
    for (int i = 0; i < 4; i++) req_flit[i*32 +: 32] = {8'(i), 24'(cyc)};
    #1;
    rdy     = model_ready(v, h, vc);
    dut_rdy = req_ready;
    if (r) chk("ready", req_ready, rdy);
    model_step(r, v, h, t, vc, ci, rdy);
    @(posedge clk);
    #1;
    chk("flit_out_wr", flit_out_wr, m_wr);
    chk("flit_out", {flit_out, flit_out_hdr, flit_out_tail, flit_out_vc},
        {m_flit, m_hdr, m_tail, m_vc});
    chk("busy", busy, m_lock);
    chk("sticky_errs", {credit_err, proto_err}, {m_cerr, m_perr});
  endtask

  typedef struct packed {
    logic       r;
    logic [3:0] v;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] vc;
    logic [1:0] ci;
    logic       cr;
    logic [3:0] rdy;
    logic       wr;
    logic [1:0] src;
    logic       busy;
    logic       cerr;
    logic       perr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] h,
                              input logic [3:0] t, input logic [3:0] vc, input logic [1:0] ci,
                              input logic cr, input logic [3:0] rdy, input logic wr,
                              input logic [1:0] src, input logic bsy, input logic cerr,
                              input logic perr);
    vec_t x;
    x.r = r; x.v = v; x.h = h; x.t = t; x.vc = vc; x.ci = ci; x.cr = cr; x.rdy = rdy;
    x.wr = wr; x.src = src; x.busy = bsy; x.cerr = cerr; x.perr = perr;
    return x;
  endfunction

  vec_t        tbl [$];
  logic [3:0]  rdy;
  logic [3:0]  drdy;
  logic [31:0] exp_hold;
  int          rem   [4];
  bit          first [4];
  logic [3:0]  pvc;
  logic [3:0]  rv, rh, rt, rvc;
  logic [1:0]  rci;
  logic        rr;

  initial begin
    reset = 1'b0; req_valid = '0; req_hdr = '0; req_tail = '0; req_vc = '0;
    credit_in = '0; req_flit = '0;

    // reset
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    // four single-flit packets on VC0 drain its credits, then a credit frees one more
    tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 2'd1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    repeat (4)
      tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    // extra credit at full count
    tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    // send + credit in the same cycle at credit 2 leaves it at 2
    repeat (2)
      tbl.push_back(mk(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 2'd1, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
    repeat (2)
      tbl.push_back(mk(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    repeat (4)
      tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    // wormhole: req1 H,B,T while req2 holds a header; req2 follows with no bubble
    tbl.push_back(mk(1'b1, 4'h6, 4'h6, 4'h0, 4'h0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h6, 4'h4, 4'h0, 4'h0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h6, 4'h4, 4'h2, 4'h0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h4, 4'h4, 4'h4, 4'h0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0));
    // VC bypass: VC0 empty, req3 on VC1 wins over req0 from ptr 0
    tbl.push_back(mk(1'b1, 4'h8, 4'h8, 4'h8, 4'h8, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h9, 4'h9, 4'h9, 4'h8, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 2'd1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
    repeat (2)
      tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    repeat (2)
      tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    // drain VC1 to one credit
    tbl.push_back(mk(1'b1, 4'h2, 4'h2, 4'h2, 4'h2, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h4, 4'h4, 4'h4, 4'h4, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h8, 4'h8, 4'h8, 4'h8, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0));
    // credit stall mid-packet on VC1; req1 header on VC0 must not slip in
    tbl.push_back(mk(1'b1, 4'h3, 4'h3, 4'h0, 4'h1, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
    repeat (2)
      tbl.push_back(mk(1'b1, 4'h3, 4'h2, 4'h0, 4'h1, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h3, 4'h2, 4'h0, 4'h1, 2'd2, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h3, 4'h2, 4'h0, 4'h1, 2'd2, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h3, 4'h2, 4'h1, 4'h1, 2'd2, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'h2, 4'h2, 4'h2, 4'h0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0));
    // reset mid-packet, then a headerless flit raises proto_err
    tbl.push_back(mk(1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
    // pointer back at 0 and exactly B credits after reset
    tbl.push_back(mk(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'h2, 4'h2, 4'h2, 4'h0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'h4, 4'h4, 4'h4, 4'h0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'h8, 4'h8, 4'h8, 4'h0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));

    foreach (tbl[n]) begin
      apply(tbl[n].r, tbl[n].v, tbl[n].h, tbl[n].t, tbl[n].vc, tbl[n].ci, rdy, drdy);
      if (tbl[n].cr) chk($sformatf("row%0d_ready", n), drdy, tbl[n].rdy);
      chk($sformatf("row%0d_wr", n), flit_out_wr, tbl[n].wr);
      if (tbl[n].wr) chk($sformatf("row%0d_src", n), flit_out[31:24], 8'(tbl[n].src));
      chk($sformatf("row%0d_busy", n), busy, tbl[n].busy);
      chk($sformatf("row%0d_errs", n), {credit_err, proto_err}, {tbl[n].cerr, tbl[n].perr});
    end

    // flit_out holds the last accepted flit across idle cycles
    apply(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, rdy, drdy);
    apply(1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 2'd0, rdy, drdy);
    apply(1'b1, 4'h1, 4'h0, 4'h1, 4'h0, 2'd0, rdy, drdy);
    exp_hold = {8'd0, 24'(cyc)};
    chk("hold_tail", {flit_out_hdr, flit_out_tail}, 2'b01);
    apply(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, rdy, drdy);
    apply(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, rdy, drdy);
    chk("hold_wr", flit_out_wr, 1'b0);
    chk("hold_data", flit_out, exp_hold);

    // random packet traffic against the model
    apply(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, rdy, drdy);
    for (int i = 0; i < 4; i++) begin rem[i] = 0; first[i] = 0; end
    pvc = '0;
    repeat (3000) begin
      rr = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
          rem[i]   = int'($urandom_range(1, 4));
          first[i] = 1;
          pvc[i]   = 1'($urandom_range(0, 1));
        end
        if (rem[i] > 0) begin
          rv[i]  = ($urandom_range(0, 3) != 0);
          rh[i]  = first[i];
          rt[i]  = (rem[i] == 1);
          rvc[i] = pvc[i];
        end else begin
          rv[i]  = ($urandom_range(0, 59) == 0);
          rh[i]  = 1'b0;
          rt[i]  = 1'($urandom_range(0, 1));
          rvc[i] = 1'($urandom_range(0, 1));
        end
      end
      rci[0] = ($urandom_range(0, 2) == 0);
      rci[1] = ($urandom_range(0, 2) == 0);
      apply(rr, rv, rh, rt, rvc, rci, rdy, drdy);
      for (int i = 0; i < 4; i++) begin
        if (!rr) rem[i] = 0;
        else if (rdy[i]) begin first[i] = 0; rem[i]--; end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
